// File: rtl/i2c_eeprom_seq_pkg.sv
// Shared constants and types for the i2c_ip EEPROM command sequencer.
// Covers register offsets, MDR command words, I2CSTR bit positions and FSM states.
package i2c_pkg;

    localparam logic [15:0] REG_MDR  = 16'd0;
    localparam logic [15:0] REG_SAR  = 16'd1;
    localparam logic [15:0] REG_OAR  = 16'd2;
    localparam logic [15:0] REG_CNT  = 16'd3;
    localparam logic [15:0] REG_DXR  = 16'd4;
    localparam logic [15:0] REG_PSC  = 16'd5;
    localparam logic [15:0] REG_CLKH = 16'd6;
    localparam logic [15:0] REG_CLKL = 16'd7;
    localparam logic [15:0] REG_DRR  = 16'd8;
    localparam logic [15:0] REG_STR  = 16'd9;

    localparam logic [15:0] MDR_TX_STP = 16'h6E20;
    localparam logic [15:0] MDR_TX     = 16'h2620;
    localparam logic [15:0] MDR_RX_STP = 16'h2C20;
    localparam logic [15:0] MDR_STP    = 16'h0820;

    localparam int ST_NACK = 1;
    localparam int ST_ARDY = 2;
    localparam int ST_RRDY = 3;
    localparam int ST_XRDY = 4;
    localparam int ST_BB   = 12;

    typedef enum logic [4:0] {
        S_INIT0, S_INIT1, S_INIT2, S_IDLE, S_SAR, S_CNT, S_MDR, S_WAIT_XRDY, S_DXR,
        S_WAIT_ARDY, S_RCNT, S_RMDR, S_WAIT_RRDY, S_RDRR, S_RCAP, S_WAIT_BB, S_ABORT, S_DONE
    } state_t;

    typedef enum logic [1:0] {B_IDLE, B_STROBE, B_GAP} bus_state_t;

    // One register access requested by the current state, and where to go once it completes.
    typedef struct packed {
        logic        en;
        logic        write;
        logic [15:0] addr;
        logic [15:0] data;
        state_t      next;
    } access_t;

    function automatic logic is_wait(state_t s);
        return s inside {S_WAIT_XRDY, S_WAIT_ARDY, S_WAIT_RRDY, S_WAIT_BB};
    endfunction

endpackage

// File: rtl/i2c_eeprom_seq_bus_wr.sv
// Single-access strobe generator for the i2c_ip register bus.
// One chip_sel cycle, then a guard cycle (read data captured there), then a done pulse.
module i2c_bus_wr
    import i2c_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        acc_write,
    input  logic [15:0] acc_addr,
    input  logic [15:0] acc_data,
    output logic        chip_sel,
    output logic        chip_write,
    output logic [15:0] chip_addr,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic        done,
    output logic [15:0] rd_data
);

    bus_state_t bus_state;

    // NOTE: registers use non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state  <= B_IDLE;
            chip_sel   <= 1'b0;
            chip_write <= 1'b0;
            chip_addr  <= '0;
            wdata      <= '0;
            done       <= 1'b0;
            rd_data    <= '0;
        end else begin
            chip_sel <= 1'b0;
            done     <= 1'b0;
            case (bus_state)
                B_IDLE: if (start) begin
                    chip_sel   <= 1'b1;
                    chip_write <= acc_write;
                    chip_addr  <= acc_addr;
                    wdata      <= acc_data;
                    bus_state  <= B_STROBE;
                end
                B_STROBE: bus_state <= B_GAP;
                B_GAP: begin
                    if (!chip_write) rd_data <= rdata;
                    done      <= 1'b1;
                    bus_state <= B_IDLE;
                end
                default: bus_state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/i2c_eeprom_seq.sv
// EEPROM byte read/write sequencer driving i2c_ip through its register bus.
// Each access state issues one bus access; WAIT_* states poll I2CSTR with NACK/timeout abort.
module i2c_eeprom_seq
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter logic [15:0] PSC_VAL  = 16'd4,
    parameter logic [15:0] CLKH_VAL = 16'd10,
    parameter logic [15:0] CLKL_VAL = 16'd10,
    parameter logic [19:0] TIMEOUT  = 20'd200000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [12:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        chip_sel,
    output logic        chip_write,
    output logic [15:0] chip_addr,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    input  logic [15:0] status
);

    state_t      state;
    access_t     acc;
    logic        init_done, issued, start, err, lat_write;
    logic [12:0] lat_addr;
    logic [7:0]  lat_wdata, dxr_byte;
    logic [1:0]  byte_idx;
    logic [19:0] tmo_cnt;
    logic        bus_done, last_byte, wait_ok;
    logic [15:0] bus_rdata;
    state_t      wait_next;
    logic        unused_bits;

    assign unused_bits = ^{status[15:13], status[11:5], status[0], bus_rdata[15:8]};

    always_comb begin
        case (byte_idx)
            2'd0:    dxr_byte = {3'b000, lat_addr[12:8]};
            2'd1:    dxr_byte = lat_addr[7:0];
            default: dxr_byte = lat_wdata;
        endcase
        last_byte = lat_write ? (byte_idx == 2'd2) : (byte_idx == 2'd1);
    end

    always_comb begin
        acc       = '0;
        acc.next  = S_IDLE;
        wait_ok   = 1'b0;
        wait_next = S_IDLE;
        case (state)
            S_INIT0: acc = '{1'b1, 1'b1, REG_PSC,  PSC_VAL,  S_INIT1};
            S_INIT1: acc = '{1'b1, 1'b1, REG_CLKH, CLKH_VAL, S_INIT2};
            S_INIT2: acc = '{1'b1, 1'b1, REG_CLKL, CLKL_VAL, S_IDLE};
            S_SAR:   acc = '{1'b1, 1'b1, REG_SAR, {9'd0, DEV_ADDR}, S_CNT};
            S_CNT:   acc = '{1'b1, 1'b1, REG_CNT, lat_write ? 16'd3 : 16'd2, S_MDR};
            S_MDR:   acc = '{1'b1, 1'b1, REG_MDR, lat_write ? MDR_TX_STP : MDR_TX, S_WAIT_XRDY};
            S_DXR:   acc = '{1'b1, 1'b1, REG_DXR, {8'd0, dxr_byte},
                            last_byte ? (lat_write ? S_WAIT_BB : S_WAIT_ARDY) : S_WAIT_XRDY};
            S_RCNT:  acc = '{1'b1, 1'b1, REG_CNT, 16'd1, S_RMDR};
            S_RMDR:  acc = '{1'b1, 1'b1, REG_MDR, MDR_RX_STP, S_WAIT_RRDY};
            S_RDRR:  acc = '{1'b1, 1'b0, REG_DRR, 16'd0, S_RCAP};
            S_ABORT: acc = '{1'b1, 1'b1, REG_MDR, MDR_STP, S_WAIT_BB};
            S_WAIT_XRDY: begin wait_ok = status[ST_XRDY]; wait_next = S_DXR;  end
            S_WAIT_ARDY: begin wait_ok = status[ST_ARDY]; wait_next = S_RCNT; end
            S_WAIT_RRDY: begin wait_ok = status[ST_RRDY]; wait_next = S_RDRR; end
            S_WAIT_BB:   begin wait_ok = !status[ST_BB];  wait_next = S_DONE; end
            default: ;
        endcase
    end

    i2c_bus_wr u_bus (
        .clk(CLK), .rst(rst), .start(start),
        .acc_write(acc.write), .acc_addr(acc.addr), .acc_data(acc.data),
        .chip_sel(chip_sel), .chip_write(chip_write), .chip_addr(chip_addr), .wdata(wdata),
        .rdata(rdata), .done(bus_done), .rd_data(bus_rdata)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= S_INIT0;
            init_done <= 1'b0;
            issued    <= 1'b0;
            start     <= 1'b0;
            err       <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            byte_idx  <= '0;
            tmo_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            start     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= is_wait(state) ? tmo_cnt + 20'd1 : '0;

            // An access is launched once per state entry; the state advances on its done pulse.
            if (acc.en) begin
                if (bus_done) begin
                    issued <= 1'b0;
                    state  <= acc.next;
                    if (state == S_INIT2) begin
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                    if (state == S_DXR && !last_byte) byte_idx <= byte_idx + 2'd1;
                    if (state == S_ABORT) err <= 1'b1;
                end else if (!issued) begin
                    start  <= 1'b1;
                    issued <= 1'b1;
                end
            end

            if (is_wait(state)) begin
                if (err) begin
                    if (wait_ok) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end else if (status[ST_NACK]) begin
                    state <= S_ABORT;
                end else if (wait_ok) begin
                    state     <= wait_next;
                    rsp_valid <= (wait_next == S_DONE);
                end else if (tmo_cnt == TIMEOUT - 20'd1) begin
                    state <= S_ABORT;
                end
            end

            case (state)
                S_IDLE: if (req_valid && req_ready && init_done) begin
                    lat_write <= req_write;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    byte_idx  <= '0;
                    err       <= 1'b0;
                    req_ready <= 1'b0;
                    state     <= S_SAR;
                end
                S_RCAP: begin
                    rsp_rdata <= bus_rdata[7:0];
                    state     <= S_WAIT_BB;
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Self-checking bench for i2c_eeprom_seq: table of EEPROM transactions plus
// hand-written init, timeout, held-request and mid-transfer reset sequences.
module tb_i2c_eeprom_seq;

    localparam logic [15:0] ST_ACK  = 16'h001C;  // XRDY|RRDY|ARDY, bus free
    localparam logic [15:0] ST_NACK = 16'h001E;  // same plus NACK

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [12:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        chip_sel, chip_write;
    logic [15:0] chip_addr, wdata, rdata;
    logic [15:0] status = ST_ACK;
    logic [7:0]  slave_byte = 8'h00;

    assign rdata = {8'hA5, slave_byte};

    always #5 CLK = ~CLK;

    i2c_eeprom_seq #(.TIMEOUT(20'd100)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .chip_sel(chip_sel), .chip_write(chip_write), .chip_addr(chip_addr), .wdata(wdata),
        .rdata(rdata), .status(status)
    );

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  wd;
        logic [15:0] st;
        logic [7:0]  sb;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    acc_t acc_q[$];
    int   errors = 0, checks = 0, cyc = 0, rsp_cnt = 0;
    logic prev_sel = 1'b0, b2b = 1'b0;
    logic        exp_w[16];
    logic [15:0] exp_a[16], exp_d[16];
    int          n_exp;
    vec_t        vecs[8];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (chip_sel) begin
            acc_q.push_back('{chip_write, chip_addr, wdata, cyc});
            if (prev_sel) b2b = 1'b1;
        end
        prev_sel = chip_sel;
        if (rsp_valid) rsp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic add_exp(input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_w[n_exp] = w;
        exp_a[n_exp] = a;
        exp_d[n_exp] = d;
        n_exp++;
    endtask

    // Expected register traffic for one transaction, written straight from the protocol.
    task automatic build_exp(input vec_t v);
        n_exp = 0;
        add_exp(1'b1, 16'd1, 16'h0050);
        add_exp(1'b1, 16'd3, v.wr ? 16'd3 : 16'd2);
        add_exp(1'b1, 16'd0, v.wr ? 16'h6E20 : 16'h2620);
        if (v.st[1]) begin
            add_exp(1'b1, 16'd0, 16'h0820);
        end else begin
            add_exp(1'b1, 16'd4, {11'd0, v.addr[12:8]});
            add_exp(1'b1, 16'd4, {8'd0, v.addr[7:0]});
            if (v.wr) begin
                add_exp(1'b1, 16'd4, {8'd0, v.wd});
            end else begin
                add_exp(1'b1, 16'd3, 16'd1);
                add_exp(1'b1, 16'd0, 16'h2C20);
                add_exp(1'b0, 16'd8, 16'd0);
            end
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_n_acc"}, acc_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < acc_q.size(); i++) begin
            check($sformatf("%s_acc%0d_wr", tag, i), acc_q[i].write, exp_w[i]);
            check($sformatf("%s_acc%0d_addr", tag, i), acc_q[i].addr, exp_a[i]);
            if (exp_w[i]) check($sformatf("%s_acc%0d_data", tag, i), acc_q[i].data, exp_d[i]);
        end
    endtask

    task automatic check_init(input string tag);
        check({tag, "_n_init"}, acc_q.size(), 3);
        if (acc_q.size() >= 3) begin
            check({tag, "_psc"},  {acc_q[0].write, acc_q[0].addr, acc_q[0].data}, {1'b1, 16'd5, 16'd4});
            check({tag, "_clkh"}, {acc_q[1].write, acc_q[1].addr, acc_q[1].data}, {1'b1, 16'd6, 16'd10});
            check({tag, "_clkl"}, {acc_q[2].write, acc_q[2].addr, acc_q[2].data}, {1'b1, 16'd7, 16'd10});
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            if (req_ready) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string tag, output bit seen);
        seen = 0;
        for (int k = 0; k < 2000; k++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int n);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            if (acc_q.size() >= n) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check({tag, "_acc_timeout"}, acc_q.size(), n);
    endtask

    task automatic send_req(input vec_t v, input string tag);
        status     = v.st;
        slave_byte = v.sb;
        wait_ready(tag);
        acc_q.delete();
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wd;
        tick();
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wd;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int base = rsp_cnt;
        bit seen;
        send_req(v, tag);
        wait_rsp(tag, seen);
        if (seen) begin
            check({tag, "_err"}, rsp_err, v.exp_err);
            check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
            tick();
            check({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
            check({tag, "_ready_back"}, req_ready, 1'b1);
            check({tag, "_rsp_count"}, rsp_cnt - base, 1);
        end
        build_exp(v);
        check_log(tag);
    endtask

    initial begin
        vec_t tv;
        bit   seen;
        int   base;

        vecs[0] = '{1'b1, 13'h0ABC, 8'h5A, ST_ACK,  8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 13'h1FFF, 8'h00, ST_ACK,  8'hC3, 1'b0, 8'hC3};
        vecs[2] = '{1'b1, 13'h0000, 8'hFF, ST_ACK,  8'h00, 1'b0, 8'hC3};
        vecs[3] = '{1'b0, 13'h0123, 8'h00, ST_ACK,  8'h3C, 1'b0, 8'h3C};
        vecs[4] = '{1'b0, 13'h0456, 8'h00, ST_NACK, 8'h99, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 13'h1ABC, 8'h11, ST_NACK, 8'h00, 1'b1, 8'h3C};
        vecs[6] = '{1'b0, 13'h1000, 8'h00, ST_ACK,  8'h00, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 13'h1FFF, 8'h80, ST_ACK,  8'h00, 1'b0, 8'h00};

        // Reset state and the init register sequence.
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_chip_sel", chip_sel, 1'b0);
        rst = 1'b0;
        wait_acc("init", 3);
        check("init_ready_low", req_ready, 1'b0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (req_ready) begin
                seen = 1;
                break;
            end
        end
        check("init_ready_rise", seen, 1'b1);
        check_init("init");

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stuck status: abort after 100 cycles in WAIT_XRDY. MDR strobe -> WAIT entry is
        // 3 cycles, 100 wait cycles, then ABORT entry -> its strobe is 2 more.
        tv = '{1'b1, 13'h0ABC, 8'h33, 16'h0000, 8'h00, 1'b1, 8'h00};
        send_req(tv, "tmo");
        wait_rsp("tmo", seen);
        if (seen) begin
            check("tmo_err", rsp_err, 1'b1);
            check("tmo_rdata", rsp_rdata, 8'h00);
        end
        check("tmo_n_acc", acc_q.size(), 4);
        if (acc_q.size() >= 4) begin
            check("tmo_stp", {acc_q[3].addr, acc_q[3].data}, {16'd0, 16'h0820});
            check("tmo_gap", acc_q[3].cyc - acc_q[2].cyc, 105);
        end

        // req_valid held through the whole transfer yields one response only.
        status = ST_ACK;
        wait_ready("held");
        acc_q.delete();
        base      = rsp_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 13'h0155;
        req_wdata = 8'h77;
        wait_rsp("held", seen);
        req_valid = 1'b0;
        repeat (40) tick();
        check("held_rsp_count", rsp_cnt - base, 1);
        check("held_n_acc", acc_q.size(), 6);

        // Reset in the middle of a read restarts the init sequence with no response.
        tv = '{1'b0, 13'h0ABC, 8'h00, ST_ACK, 8'h42, 1'b0, 8'h00};
        send_req(tv, "midrst");
        wait_acc("midrst", 4);
        rst = 1'b1;
        tick();
        check("midrst_chip_sel", chip_sel, 1'b0);
        check("midrst_ready", req_ready, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        tick();
        acc_q.delete();
        base = rsp_cnt;
        rst  = 1'b0;
        wait_acc("reinit", 3);
        wait_ready("reinit");
        check_init("reinit");
        check("reinit_no_rsp", rsp_cnt - base, 0);
        check("reinit_rdata", rsp_rdata, 8'h00);

        tv = '{1'b0, 13'h0777, 8'h00, ST_ACK, 8'h5E, 1'b0, 8'h5E};
        run_txn(tv, "after_rst");

        check("no_back_to_back", b2b, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
